// File: rtl/pc_gen_if.sv
// Fetch-side bus of pc_gen: the redirect channels in, the PC valid/ready handshake out.
interface pc_gen_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_REDIR = 3
);
  logic [NUM_REDIR-1:0]       redir_valid;
  logic [NUM_REDIR*WIDTH-1:0] redir_target;
  logic [WIDTH-1:0]           pc;
  logic                       pc_valid;
  logic                       pc_ready;

  modport master (
    input  redir_valid, redir_target, pc_ready,
    output pc, pc_valid
  );

  modport slave (
    output redir_valid, redir_target, pc_ready,
    input  pc, pc_valid
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator with prioritised redirects, stall and halt/resume.
// Optional issued-PC trace ring and fire counter under `ifdef PC_GEN_TRACE_EN.
module pc_gen #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VAL   = 32'h80000000,
  parameter int unsigned      STEP        = 4,
  parameter int unsigned      NUM_REDIR   = 3,
  parameter int unsigned      ALIGN_BITS  = 2,
  parameter int unsigned      TRACE_DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  pc_gen_if.master bus,
  input  logic stall,
  input  logic halt,
  input  logic resume,
  output logic misalign,
  output logic halted
`ifdef PC_GEN_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [WIDTH-1:0]               trace_pc,
  output logic [31:0]                    issue_cnt
`endif
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_q;
  logic             pc_valid_c;
  logic             fire;
  logic             redir_hit;
  logic [WIDTH-1:0] redir_sel;

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_c;
  assign fire         = pc_valid_c & bus.pc_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (halt)   state_nxt = HALTED;
      HALTED:  if (resume) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    pc_valid_c = 1'b0;
    halted     = 1'b0;
    case (state)
      RUN:     pc_valid_c = !stall;
      HALTED:  halted     = 1'b1;
      default: ;
    endcase
  end

  // Lowest set channel index wins.
  always_comb begin
    redir_hit = 1'b0;
    redir_sel = '0;
    for (int unsigned i = 0; i < NUM_REDIR; i++) begin
      if (bus.redir_valid[i] && !redir_hit) begin
        redir_hit = 1'b1;
        redir_sel = bus.redir_target[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_VAL;
      misalign <= 1'b0;
    end else begin
      misalign <= redir_hit && ((redir_sel & ALIGN_MASK) != '0);
      if (redir_hit)  pc_q <= redir_sel & ~ALIGN_MASK;
      else if (fire)  pc_q <= pc_q + STEP_W;
    end
  end

`ifdef PC_GEN_TRACE_EN
  localparam int unsigned PW = $clog2(TRACE_DEPTH);

  logic [WIDTH-1:0] trace_mem [TRACE_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
      wr_ptr    <= '0;
      issue_cnt <= '0;
    end else if (fire) begin
      trace_mem[wr_ptr] <= pc_q;
      wr_ptr            <= wr_ptr + PW'(1);
      issue_cnt         <= issue_cnt + 32'd1;
    end
  end

  // wr_ptr points at the next free slot, so the newest entry is one behind it.
  assign rd_ptr   = wr_ptr - PW'(1) - trace_idx;
  assign trace_pc = trace_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: vector table for the main flow plus hand sequences
// for wrap-around, asynchronous reset, redirect in BOOT and the optional trace.
module tb_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst8_n;
  logic stall, halt, resume, misalign, halted;
  logic stall8, halt8, resume8, misalign8, halted8;

  pc_gen_if #(.WIDTH(32), .NUM_REDIR(3)) bus ();
  pc_gen_if #(.WIDTH(8),  .NUM_REDIR(3)) bus8 ();

`ifdef PC_GEN_TRACE_EN
  logic [2:0]  trace_idx, trace_idx8;
  logic [31:0] trace_pc, issue_cnt, issue_cnt8;
  logic [7:0]  trace_pc8;
`endif

  pc_gen #(
    .WIDTH(32), .RESET_VAL(32'h80000000), .STEP(4),
    .NUM_REDIR(3), .ALIGN_BITS(2), .TRACE_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .stall(stall), .halt(halt), .resume(resume),
    .misalign(misalign), .halted(halted)
`ifdef PC_GEN_TRACE_EN
    , .trace_idx(trace_idx), .trace_pc(trace_pc), .issue_cnt(issue_cnt)
`endif
  );

  pc_gen #(
    .WIDTH(8), .RESET_VAL(8'hF8), .STEP(4),
    .NUM_REDIR(3), .ALIGN_BITS(2), .TRACE_DEPTH(8)
  ) dut8 (
    .clk(clk), .rst_n(rst8_n), .bus(bus8),
    .stall(stall8), .halt(halt8), .resume(resume8),
    .misalign(misalign8), .halted(halted8)
`ifdef PC_GEN_TRACE_EN
    , .trace_idx(trace_idx8), .trace_pc(trace_pc8), .issue_cnt(issue_cnt8)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  rv;
    logic [31:0] t0, t1, t2;
    logic        stl, hlt, res, rdy;
    logic [31:0] pc;
    logic        v, mis, h;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [2:0] rv, input logic [31:0] t0, t1, t2,
                              input logic stl, hlt, res, rdy,
                              input logic [31:0] pc, input logic v, mis, h);
    vec_t r;
    r.rv = rv; r.t0 = t0; r.t1 = t1; r.t2 = t2;
    r.stl = stl; r.hlt = hlt; r.res = res; r.rdy = rdy;
    r.pc = pc; r.v = v; r.mis = mis; r.h = h;
    return r;
  endfunction

  task automatic drive(input logic [2:0] rv, input logic [31:0] t0, t1, t2,
                       input logic stl, hlt, res, rdy);
    bus.redir_valid  = rv;
    bus.redir_target = {t2, t1, t0};
    stall  = stl;
    halt   = hlt;
    resume = res;
    bus.pc_ready = rdy;
  endtask

  initial begin
    // Each row: inputs held for one cycle and the outputs expected in that same cycle.
    tbl[0]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 32'h80000000, 0, 0, 0);
    tbl[1]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 32'h80000000, 1, 0, 0);
    tbl[2]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h80000004, 1, 0, 0);
    tbl[3]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h80000004, 1, 0, 0);
    tbl[4]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h80000004, 1, 0, 0);
    tbl[5]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 32'h80000004, 1, 0, 0);
    tbl[6]  = mk(3'b110, 0, 32'h80001000, 32'h80002000, 0, 0, 0, 1, 32'h80000008, 1, 0, 0);
    tbl[7]  = mk(3'b001, 32'h80003003, 0, 0, 0, 0, 0, 1, 32'h80001000, 1, 0, 0);
    tbl[8]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h80003000, 1, 1, 0);
    tbl[9]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h80003000, 1, 0, 0);
    tbl[10] = mk(3'b000, 0, 0, 0, 1, 0, 0, 1, 32'h80003000, 0, 0, 0);
    tbl[11] = mk(3'b010, 0, 32'h80000010, 0, 1, 0, 0, 1, 32'h80003000, 0, 0, 0);
    tbl[12] = mk(3'b000, 0, 0, 0, 0, 1, 0, 1, 32'h80000010, 1, 0, 0);
    tbl[13] = mk(3'b100, 0, 0, 32'h80000100, 0, 0, 0, 1, 32'h80000014, 0, 0, 1);
    tbl[14] = mk(3'b000, 0, 0, 0, 0, 1, 0, 1, 32'h80000100, 0, 0, 1);
    tbl[15] = mk(3'b000, 0, 0, 0, 0, 0, 1, 1, 32'h80000100, 0, 0, 1);
    tbl[16] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 32'h80000100, 1, 0, 0);
    tbl[17] = mk(3'b000, 0, 0, 0, 0, 0, 1, 1, 32'h80000104, 1, 0, 0);
    tbl[18] = mk(3'b011, 32'h80000202, 32'h80000300, 0, 0, 0, 0, 1, 32'h80000108, 1, 0, 0);
    tbl[19] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h80000200, 1, 1, 0);
    tbl[20] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h80000200, 1, 0, 0);

    rst_n = 1'b0; rst8_n = 1'b0;
    drive(3'b000, 0, 0, 0, 0, 0, 0, 0);
    stall8 = 1'b0; halt8 = 1'b0; resume8 = 1'b0;
    bus8.redir_valid = '0; bus8.redir_target = '0; bus8.pc_ready = 1'b1;
`ifdef PC_GEN_TRACE_EN
    trace_idx = '0; trace_idx8 = '0;
`endif

    // 8-bit instance: silent wrap of the PC.
    @(negedge clk);
    #1 chk("w8_reset_pc", 32'(bus8.pc), 32'hF8);
    @(negedge clk);
    rst8_n = 1'b1;
    #1;
    chk("w8_boot_pc", 32'(bus8.pc), 32'hF8);
    chk("w8_boot_valid", 32'(bus8.pc_valid), 0);
    @(negedge clk); #1 chk("w8_pc0", 32'(bus8.pc), 32'hF8);
    chk("w8_valid", 32'(bus8.pc_valid), 1);
    @(negedge clk); #1 chk("w8_pc1", 32'(bus8.pc), 32'hFC);
    @(negedge clk); #1 chk("w8_pc2", 32'(bus8.pc), 32'h00);
    @(negedge clk); #1 chk("w8_pc3", 32'(bus8.pc), 32'h04);
    rst8_n = 1'b0;

    // Main instance reset state.
    chk("reset_pc", bus.pc, 32'h80000000);
    chk("reset_valid", 32'(bus.pc_valid), 0);
    chk("reset_halted", 32'(halted), 0);
    chk("reset_misalign", 32'(misalign), 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rv, tbl[i].t0, tbl[i].t1, tbl[i].t2,
            tbl[i].stl, tbl[i].hlt, tbl[i].res, tbl[i].rdy);
      #1;
      chk($sformatf("v%0d_pc", i), bus.pc, tbl[i].pc);
      chk($sformatf("v%0d_valid", i), 32'(bus.pc_valid), 32'(tbl[i].v));
      chk($sformatf("v%0d_misalign", i), 32'(misalign), 32'(tbl[i].mis));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(tbl[i].h));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a high clock phase.
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", bus.pc, 32'h80000000);
    chk("async_rst_valid", 32'(bus.pc_valid), 0);
    chk("async_rst_halted", 32'(halted), 0);

    // Redirect applied while in BOOT; state still moves on to RUN.
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b001, 32'h80000020, 0, 0, 0, 0, 0, 1);
    #1;
    chk("boot_pc", bus.pc, 32'h80000000);
    chk("boot_valid", 32'(bus.pc_valid), 0);
    @(negedge clk);
    drive(3'b000, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("boot_redir_pc", bus.pc, 32'h80000020);
    chk("boot_redir_valid", 32'(bus.pc_valid), 1);

`ifdef PC_GEN_TRACE_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    trace_idx = 3'd0;
    #1;
    chk("tr_empty_pc", trace_pc, 0);
    chk("tr_empty_cnt", issue_cnt, 0);
    @(negedge clk);
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) @(negedge clk);
    drive(3'b000, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("tr_pc_after10", bus.pc, 32'h80000028);
    chk("tr_cnt10", issue_cnt, 32'd10);
    chk("tr_idx0", trace_pc, 32'h80000024);
    trace_idx = 3'd7;
    #1 chk("tr_idx7", trace_pc, 32'h80000008);
    trace_idx = 3'd2;
    #1 chk("tr_idx2", trace_pc, 32'h8000001C);
    rst_n = 1'b0;
    #1;
    chk("tr_rst_cnt", issue_cnt, 0);
    chk("tr_rst_pc", bus.pc, 32'h80000000);
    chk("tr_rst_buf", trace_pc, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
